// File: rtl/axis_2_dac_stream.sv
// rtl/axis_2_dac_stream.sv - AXI-Stream sample FIFO feeding a strobed 8-bit DAC register
// Optional packet length checker enabled by defining AXIS2DAC_PKT_CHECK_EN.
module axis_2_dac_stream #(
    parameter int PACKAGE_SIZE = 8192,
    parameter int FIFO_DEPTH   = 16,
    parameter int PREFILL      = 8,
    parameter int CLK_DIV      = 1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic [7:0] Offset,
    output logic [7:0] DAC_Data,
    output logic       DAC_CLK,
    output logic       underflow,
    output logic       pkt_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2");
    end
    if (PREFILL < 1 || PREFILL > FIFO_DEPTH) begin : g_bad_prefill
        $error("PREFILL must lie in 1..FIFO_DEPTH");
    end
    if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("CLK_DIV must lie in 1..65535");
    end
    if (PACKAGE_SIZE < 1 || PACKAGE_SIZE > 65536) begin : g_bad_package_size
        $error("PACKAGE_SIZE must fit the 16-bit sample counter");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN
    } state_t;

    state_t        state;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fill;
    logic [CW-1:0] tlast_fill;
    logic [DW-1:0] div_cnt;
    logic [8:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          strobe;
    logic          push_last;
    logic          pop_last;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // tready only looks at the registered fill, so a pop from full cannot open a same-cycle push
    assign full          = (fill == CW'(FIFO_DEPTH));
    assign empty         = (fill == '0);
    assign s_axis_tready = aresetn & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign strobe        = (div_cnt == DW'(CLK_DIV - 1));
    assign head          = mem[rd_ptr];
    assign pop           = (state == S_RUN) & strobe & ~empty;
    assign push_last     = push & s_axis_tlast;
    assign pop_last      = pop & head[8];
    assign DAC_CLK       = ~aclk;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            tlast_fill <= '0;
            div_cnt    <= '0;
            DAC_Data   <= 8'd0;
            underflow  <= 1'b0;
        end else begin
            div_cnt   <= strobe ? '0 : div_cnt + DW'(1);
            underflow <= 1'b0;

            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, pop})
                2'b10:   fill <= fill + CW'(1);
                2'b01:   fill <= fill - CW'(1);
                default: fill <= fill;
            endcase

            // Count of buffered tlast entries drives the short-packet flush
            case ({push_last, pop_last})
                2'b10:   tlast_fill <= tlast_fill + CW'(1);
                2'b01:   tlast_fill <= tlast_fill - CW'(1);
                default: tlast_fill <= tlast_fill;
            endcase

            case (state)
                S_IDLE: begin
                    if (push) begin
                        state <= S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    if (fill >= CW'(PREFILL) || tlast_fill != '0) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (strobe) begin
                        if (!empty) begin
                            DAC_Data <= head[7:0] + Offset;
                        end else begin
                            underflow <= 1'b1;
                            state     <= S_PREFILL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AXIS2DAC_PKT_CHECK_EN
    localparam logic [15:0] PKT_LAST = 16'(PACKAGE_SIZE - 1);

    logic [15:0] pkt_cnt;

    // pkt_cnt counts samples popped since the last tlast; PKT_LAST is where tlast belongs
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_cnt <= 16'd0;
            pkt_err <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (pop) begin
                if (head[8]) begin
                    pkt_err <= (pkt_cnt != PKT_LAST);
                    pkt_cnt <= 16'd0;
                end else if (pkt_cnt == PKT_LAST) begin
                    pkt_err <= 1'b1;
                    pkt_cnt <= 16'd0;
                end else begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_2_dac_stream.sv
// tb/tb_axis_2_dac_stream.sv - queue-model bench for axis_2_dac_stream at CLK_DIV 1 and 4
module tb_axis_2_dac_stream;
    localparam int DEPTH = 16;
    localparam int PRE   = 8;
    localparam int PKT   = 4;
`ifdef AXIS2DAC_PKT_CHECK_EN
    localparam int EXP_PKT_ERRS = 1;
`else
    localparam int EXP_PKT_ERRS = 0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic [7:0] offset;
    logic       rdy  [2];
    logic       dclk [2];
    logic       und  [2];
    logic       perr [2];
    logic [7:0] dac  [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 aclk = ~aclk;

    axis_2_dac_stream #(.PACKAGE_SIZE(PKT), .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .CLK_DIV(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(rdy[0]), .s_axis_tlast(tlast), .Offset(offset), .DAC_Data(dac[0]),
        .DAC_CLK(dclk[0]), .underflow(und[0]), .pkt_err(perr[0])
    );

    axis_2_dac_stream #(.PACKAGE_SIZE(PKT), .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .CLK_DIV(4)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(rdy[1]), .s_axis_tlast(tlast), .Offset(offset), .DAC_Data(dac[1]),
        .DAC_CLK(dclk[1]), .underflow(und[1]), .pkt_err(perr[1])
    );

    // Reference: each DUT is a list of buffered {tlast,data} plus a playback mode 0=idle 1=prefill 2=run
    int         cdiv  [2] = '{1, 4};
    logic [8:0] mlist [2][DEPTH];
    int         msz   [2];
    int         mmode [2];
    int         mdiv  [2];
    int         mpcnt [2];
    logic [7:0] mdac  [2];
    logic       mund  [2];
    logic       mperr [2];

    function automatic bit has_last(input int k);
        for (int i = 0; i < msz[k]; i++) begin
            if (mlist[k][i][8]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input int k);
        bit         push;
        bit         strobe;
        int         sum;
        logic [8:0] e;
        if (!aresetn) begin
            msz[k] = 0; mmode[k] = 0; mdiv[k] = 0; mpcnt[k] = 0;
            mdac[k] = 8'd0; mund[k] = 1'b0; mperr[k] = 1'b0;
            return;
        end
        push     = tvalid && (msz[k] < DEPTH);
        strobe   = (mdiv[k] == cdiv[k] - 1);
        mund[k]  = 1'b0;
        mperr[k] = 1'b0;
        if (mmode[k] == 0) begin
            if (push) mmode[k] = 1;
        end else if (mmode[k] == 1) begin
            if (msz[k] >= PRE || has_last(k)) mmode[k] = 2;
        end else if (strobe) begin
            if (msz[k] > 0) begin
                e = mlist[k][0];
                for (int i = 0; i < DEPTH - 1; i++) mlist[k][i] = mlist[k][i + 1];
                msz[k]  = msz[k] - 1;
                sum     = int'(e[7:0]) + int'(offset);
                mdac[k] = 8'(sum % 256);
`ifdef AXIS2DAC_PKT_CHECK_EN
                if (e[8]) begin
                    mperr[k] = (mpcnt[k] != PKT - 1);
                    mpcnt[k] = 0;
                end else if (mpcnt[k] == PKT - 1) begin
                    mperr[k] = 1'b1;
                    mpcnt[k] = 0;
                end else begin
                    mpcnt[k] = mpcnt[k] + 1;
                end
`endif
            end else begin
                mund[k]  = 1'b1;
                mmode[k] = 1;
            end
        end
        if (push) begin
            mlist[k][msz[k]] = {tlast, tdata};
            msz[k] = msz[k] + 1;
        end
        mdiv[k] = (mdiv[k] + 1) % cdiv[k];
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(posedge aclk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge aclk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check("tready", k, 32'(rdy[k]), 32'(aresetn && (msz[k] < DEPTH)));
                check("dac_data", k, 32'(dac[k]), 32'(mdac[k]));
                check("underflow", k, 32'(und[k]), 32'(mund[k]));
                check("pkt_err", k, 32'(perr[k]), 32'(mperr[k]));
                check("dac_clk", k, 32'(dclk[k]), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        int cnt2;
        logic [7:0] prev;

        aresetn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = 8'd0; offset = 8'h80;
        repeat (3) tick();
        check("reset_dac", 0, 32'(dac[0]), 32'h00);
        check("reset_dac", 1, 32'(dac[1]), 32'h00);
        check("reset_tready", 0, 32'(rdy[0]), 32'd0);
        check("reset_underflow", 0, 32'(und[0]), 32'd0);
        check("reset_pkt_err", 0, 32'(perr[0]), 32'd0);
        cmp_en  = 1'b1;
        aresetn = 1'b1;
        #1;
        check("tready_after_reset", 0, 32'(rdy[0]), 32'd1);

        // Ten beats at one sample per cycle; playback starts once eight are buffered
        for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
        check("first_sample", 0, 32'(dac[0]), 32'h80);
        tvalid = 1'b0;
        tick();
        check("second_sample", 0, 32'(dac[0]), 32'h81);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (und[0]) cnt++;
        end
        check("underflow_pulses", 0, 32'(cnt), 32'd1);
        check("hold_after_underflow", 0, 32'(dac[0]), 32'h89);

        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
        tvalid = 1'b0;
        tick();
        tick();
        check("resume_sample", 0, 32'(dac[0]), 32'h90);
        repeat (20) tick();

        // Continuous stream: the CLK_DIV=4 instance saturates and admits one beat per pop
        offset = 8'h05;
        for (int i = 0; i < 60; i++) send(8'(i), 1'b0);
        cnt  = 0;
        cnt2 = 0;
        prev = dac[1];
        for (int i = 0; i < 40; i++) begin
            send(8'(60 + i), 1'b0);
            if (dac[1] != prev) cnt++;
            prev = dac[1];
            if (!rdy[1]) cnt2++;
        end
        check("div4_updates", 1, 32'(cnt), 32'd10);
        check("div4_tready_low", 1, 32'(cnt2), 32'd30);

        // One-cycle reset while both instances hold buffered samples
        tvalid  = 1'b0;
        aresetn = 1'b0;
        #1;
        check("tready_in_reset", 0, 32'(rdy[0]), 32'd0);
        check("tready_in_reset", 1, 32'(rdy[1]), 32'd0);
        tick();
        check("dac_after_reset", 0, 32'(dac[0]), 32'h00);
        check("dac_after_reset", 1, 32'(dac[1]), 32'h00);
        aresetn = 1'b1;
        #1;
        check("tready_release", 1, 32'(rdy[1]), 32'd1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (und[0] || und[1] || dac[0] != 8'h00 || dac[1] != 8'h00) cnt++;
        end
        check("no_stale_output", 0, 32'(cnt), 32'd0);

        // Short packet flushes before PREFILL is reached; length 3 against PACKAGE_SIZE 4
        offset = 8'h80;
        cnt = 0;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (perr[0]) cnt++;
        end
        check("short_packet_last", 0, 32'(dac[0]), 32'h22);
        tick();
        check("short_packet_underflow", 0, 32'(und[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (perr[0]) cnt++;
        end
        check("pkt_err_short", 0, 32'(cnt), 32'(EXP_PKT_ERRS));

        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send(8'hB0 + 8'(i), i == 3);
            if (perr[0]) cnt++;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (perr[0]) cnt++;
        end
        check("pkt_err_good", 0, 32'(cnt), 32'd0);
        check("good_packet_last", 0, 32'(dac[0]), 32'h33);

        // Randomised traffic with varying duty, packet ends, offsets and occasional resets
        for (int seg = 0; seg < 15; seg++) begin
            int duty;
            duty = $urandom_range(1, 8);
            for (int i = 0; i < 200; i++) begin
                tvalid = ($urandom_range(0, 7) < duty);
                tdata  = 8'($urandom);
                tlast  = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 3) == 0) offset = 8'($urandom);
                aresetn = ($urandom_range(0, 399) != 0);
                tick();
            end
            aresetn = 1'b1;
        end
        tvalid = 1'b0;
        repeat (40) tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
